// File: rtl/regb_fifo_serializer_pkg.sv
// Shared FSM state type and serial line levels for the FIFO-head serializer.
package regb_fifo_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
endpackage

// File: rtl/regb_fifo_serializer_if.sv
// FIFO-head pop handshake plus serial line/status bundle for regb_fifo_serializer.
interface regb_fifo_serializer_if #(parameter int WIDTH = 4);
  logic [WIDTH-1:0] fifo_data;
  logic             fifo_empty_n;
  logic             shift_out;
  logic             enable;
  logic             tx;
  logic             busy;
  logic             frame_done;

  modport slave  (input fifo_data, fifo_empty_n, enable,
                  output shift_out, tx, busy, frame_done);
  modport master (output fifo_data, fifo_empty_n, enable,
                  input shift_out, tx, busy, frame_done);
endinterface

// File: rtl/regb_fifo_serializer_baud_tick.sv
// Bit-period divider: tick is high in the last of every DIV cycles; clear holds the count at zero.
module regb_baud_tick #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic res_n,
  input  logic clear,
  output logic tick
);
  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_cnt <= '0;
    end else if (clear || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign tick = (r_cnt == LAST);
endmodule

// File: rtl/regb_fifo_serializer.sv
// Pops the FIFO head when idle and sends it as a start/data(LSB first)/[parity]/stop frame, DIV cycles per bit.
// Parity bit is present only when REGB_SER_PARITY_EN is defined; tx is registered, shift_out is combinational.
module regb_fifo_serializer
  import regb_fifo_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DIV   = 4
) (
  input logic                  clk,
  input logic                  res_n,
  regb_fifo_serializer_if.slave bus
);
  localparam int            BW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_shreg, w_shreg_nxt;
  logic [BW-1:0]    r_bitcnt, w_bitcnt_nxt;
  logic             r_tx, w_tx_nxt;
  logic             w_tick, w_pop, w_done, w_clear;
`ifdef REGB_SER_PARITY_EN
  logic             r_par, w_par_nxt;
`endif

  assign w_clear = (r_state == IDLE);

  regb_baud_tick #(.DIV(DIV)) u_baud_tick (
    .clk   (clk),
    .res_n (res_n),
    .clear (w_clear),
    .tick  (w_tick)
  );

  // Gated by res_n so the FIFO is never popped while reset is held.
  assign w_pop = res_n & (r_state == IDLE) & bus.enable & bus.fifo_empty_n;

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_state  <= IDLE;
      r_shreg  <= '0;
      r_bitcnt <= '0;
      r_tx     <= LINE_IDLE;
`ifdef REGB_SER_PARITY_EN
      r_par    <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_shreg  <= w_shreg_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_tx     <= w_tx_nxt;
`ifdef REGB_SER_PARITY_EN
      r_par    <= w_par_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_shreg_nxt  = r_shreg;
    w_bitcnt_nxt = r_bitcnt;
    w_tx_nxt     = LINE_IDLE;
    w_done       = 1'b0;
`ifdef REGB_SER_PARITY_EN
    w_par_nxt    = r_par;
`endif
    case (r_state)
      IDLE: begin
        if (w_pop) begin
          w_state_nxt  = START;
          w_shreg_nxt  = bus.fifo_data;
          w_bitcnt_nxt = '0;
`ifdef REGB_SER_PARITY_EN
          w_par_nxt    = ^bus.fifo_data;
`endif
        end
      end
      START: begin
        if (w_tick) w_state_nxt = DATA;
      end
      DATA: begin
        if (w_tick) begin
          w_shreg_nxt = r_shreg >> 1;
          if (r_bitcnt == LAST_BIT) begin
            w_bitcnt_nxt = '0;
`ifdef REGB_SER_PARITY_EN
            w_state_nxt  = PARITY;
`else
            w_state_nxt  = STOP;
`endif
          end else begin
            w_bitcnt_nxt = r_bitcnt + BW'(1);
          end
        end
      end
`ifdef REGB_SER_PARITY_EN
      PARITY: begin
        if (w_tick) w_state_nxt = STOP;
      end
`endif
      STOP: begin
        if (w_tick) begin
          w_state_nxt = IDLE;
          w_done      = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // tx is registered from the state being entered, so it lines up with that state's cycles.
    case (w_state_nxt)
      START:   w_tx_nxt = START_BIT;
      DATA:    w_tx_nxt = w_shreg_nxt[0];
`ifdef REGB_SER_PARITY_EN
      PARITY:  w_tx_nxt = r_par;
`endif
      STOP:    w_tx_nxt = STOP_BIT;
      default: w_tx_nxt = LINE_IDLE;
    endcase
  end

  assign bus.shift_out  = w_pop;
  assign bus.tx         = r_tx;
  assign bus.busy       = (r_state != IDLE);
  assign bus.frame_done = w_done;
endmodule

// File: tb/tb_regb_fifo_serializer.sv
// Self-checking bench for regb_fifo_serializer (WIDTH=4, DIV=2): vector table, corner sequences, random vs. queue model.
`timescale 1ns/1ps
module tb_regb_fifo_serializer;
  localparam int WIDTH = 4;
  localparam int DIV   = 2;
`ifdef REGB_SER_PARITY_EN
  localparam int NB = WIDTH + 3;
`else
  localparam int NB = WIDTH + 2;
`endif
  localparam int FL = NB * DIV;

  logic clk = 1'b0;
  logic res_n;
  always #5 clk = ~clk;

  regb_fifo_serializer_if #(.WIDTH(WIDTH)) bus ();
  regb_fifo_serializer #(.WIDTH(WIDTH), .DIV(DIV)) dut (.clk(clk), .res_n(res_n), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [WIDTH-1:0] word;
    logic [NB-1:0]    bits;   // serial bits in time order, leftmost first
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: serial bit i of a frame carrying word w.
  function automatic logic frame_bit(logic [WIDTH-1:0] w, int i);
    if (i == 0) return 1'b0;
    if (i <= WIDTH) return w[i-1];
`ifdef REGB_SER_PARITY_EN
    if (i == WIDTH + 1) return ^w;
`endif
    return 1'b1;
  endfunction

  function automatic logic [63:0] expand(logic [WIDTH-1:0] w);
    logic [63:0] r = '0;
    for (int c = 0; c < FL; c++) r[c] = frame_bit(w, c / DIV);
    return r;
  endfunction

  // Called at a falling edge; samples n cycles and returns aligned to a falling edge.
  task automatic grab(input int n, output logic [63:0] w, output logic [63:0] d,
                      output int pops, output int busy_n);
    w = '0; d = '0; pops = 0; busy_n = 0;
    for (int c = 0; c < n; c++) begin
      #1;
      w[c] = bus.tx;
      d[c] = bus.frame_done;
      pops   += int'(bus.shift_out);
      busy_n += int'(bus.busy);
      @(negedge clk);
    end
  endtask

  logic [63:0] w, w2, d, e;
  int pops, busy_n;
  logic [WIDTH-1:0] words[3];
  int pop_at[3];
  int idx;
  logic q[$];
  logic e_tx, e_busy, e_done, e_pop;
  int bad_cnt;

  initial begin
`ifdef REGB_SER_PARITY_EN
    vecs[0] = '{4'hA, 7'b0010101};
    vecs[1] = '{4'h7, 7'b0111011};
    vecs[2] = '{4'h0, 7'b0000001};
    vecs[3] = '{4'hF, 7'b0111101};
    vecs[4] = '{4'h5, 7'b0101001};
`else
    vecs[0] = '{4'hA, 6'b001011};
    vecs[1] = '{4'h7, 6'b011101};
    vecs[2] = '{4'h0, 6'b000001};
    vecs[3] = '{4'hF, 6'b011111};
    vecs[4] = '{4'h5, 6'b010101};
`endif

    // Reset held with a pop request present.
    res_n = 1'b0; bus.enable = 1'b1; bus.fifo_empty_n = 1'b1; bus.fifo_data = 4'h9;
    #12;
    check("rst_tx", 64'(bus.tx), 64'd1);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_shift_out", 64'(bus.shift_out), 64'd0);
    check("rst_done", 64'(bus.frame_done), 64'd0);
    @(negedge clk);
    res_n = 1'b1; bus.fifo_empty_n = 1'b0;

    // Empty FIFO for 20 cycles.
    grab(20, w, d, pops, busy_n);
    check("empty_tx", w, 64'hFFFFF);
    check("empty_pops", 64'(pops), 64'd0);
    check("empty_busy", 64'(busy_n), 64'd0);

    // Table-driven single frames.
    for (int v = 0; v < 5; v++) begin
      bus.fifo_data = vecs[v].word; bus.fifo_empty_n = 1'b1; bus.enable = 1'b1;
      #1;
      check($sformatf("tbl%0d_pop", v), 64'(bus.shift_out), 64'd1);
      @(negedge clk);
      bus.fifo_empty_n = 1'b0; bus.fifo_data = ~vecs[v].word;
      grab(FL, w, d, pops, busy_n);
      e = '0;
      for (int c = 0; c < FL; c++) e[c] = vecs[v].bits[NB-1-(c/DIV)];
      check($sformatf("tbl%0d_tx", v), w, e);
      check($sformatf("tbl%0d_done", v), d, 64'(1) << (FL - 1));
      check($sformatf("tbl%0d_pops", v), 64'(pops), 64'd0);
      check($sformatf("tbl%0d_busy", v), 64'(busy_n), 64'(FL));
      grab(1, w, d, pops, busy_n);
      check($sformatf("tbl%0d_idle", v), {w[0], 62'd0, busy_n[0]}, {1'b1, 63'd0});
    end

    // Three queued words, FIFO advances on each pop.
    words[0] = 4'h1; words[1] = 4'h2; words[2] = 4'h3;
    idx = 0; pops = 0; w = '0;
    for (int c = 0; c < 3 * (FL + 1) + 2; c++) begin
      bus.fifo_empty_n = (idx < 3);
      bus.fifo_data = (idx < 3) ? words[idx] : 4'h0;
      #1;
      w[c] = bus.tx;
      if (bus.shift_out) begin
        if (pops < 3) pop_at[pops] = c;
        pops++; idx++;
      end
      @(negedge clk);
    end
    e = '1;
    for (int k = 0; k < 3; k++)
      for (int j = 0; j < FL; j++) e[k*(FL+1)+1+j] = frame_bit(words[k], j / DIV);
    for (int c = 3 * (FL + 1) + 2; c < 64; c++) e[c] = 1'b0;
    check("three_pops", 64'(pops), 64'd3);
    check("three_tx", w, e);
    check("three_gap", {32'(pop_at[1]), 32'(pop_at[2])}, {32'(FL + 1), 32'(2 * (FL + 1))});

    // enable dropped during DATA of the first of two words.
    bus.fifo_data = 4'hA; bus.fifo_empty_n = 1'b1; bus.enable = 1'b1;
    @(negedge clk);
    bus.fifo_data = 4'h5;
    grab(3, w, d, pops, busy_n);
    bus.enable = 1'b0;
    grab(FL - 3, w2, d, idx, busy_n);
    check("en_frame_tx", w | (w2 << 3), expand(4'hA));
    check("en_frame_pops", 64'(pops + idx), 64'd0);
    grab(6, w, d, pops, busy_n);
    check("en_hold_pops", 64'(pops), 64'd0);
    check("en_hold_busy", 64'(busy_n), 64'd0);
    bus.enable = 1'b1;
    #1;
    check("en_resume_pop", 64'(bus.shift_out), 64'd1);
    @(negedge clk);
    bus.fifo_empty_n = 1'b0;
    grab(FL, w, d, pops, busy_n);
    check("en_second_tx", w, expand(4'h5));
    grab(1, w, d, pops, busy_n);

    // Reset pulsed in the first DATA cycle.
    bus.fifo_data = 4'hA; bus.fifo_empty_n = 1'b1; bus.enable = 1'b1;
    @(negedge clk);
    bus.fifo_data = 4'h7;
    grab(2, w, d, pops, busy_n);
    #1;
    check("mid_tx_before", 64'(bus.tx), 64'd0);
    #1 res_n = 1'b0;
    #1;
    check("mid_rst_tx", 64'(bus.tx), 64'd1);
    check("mid_rst_busy", 64'(bus.busy), 64'd0);
    check("mid_rst_shift", 64'(bus.shift_out), 64'd0);
    bus.fifo_empty_n = 1'b0;
    @(negedge clk);
    res_n = 1'b1;
    grab(5, w, d, pops, busy_n);
    check("post_rst_tx", w, 64'h1F);
    check("post_rst_pops", 64'(pops), 64'd0);
    bus.fifo_empty_n = 1'b1;
    #1;
    check("post_rst_pop", 64'(bus.shift_out), 64'd1);
    @(negedge clk);
    bus.fifo_empty_n = 1'b0;
    grab(FL, w, d, pops, busy_n);
    check("post_rst_frame", w, expand(4'h7));
    grab(1, w, d, pops, busy_n);

    // Random inputs against a queue of expected line values.
    bad_cnt = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bus.enable       = ($urandom_range(0, 9) < 8);
      bus.fifo_empty_n = ($urandom_range(0, 9) < 6);
      bus.fifo_data    = WIDTH'($urandom);
      #1;
      if (q.size() == 0) begin
        e_tx = 1'b1; e_busy = 1'b0; e_done = 1'b0;
        e_pop = bus.enable & bus.fifo_empty_n;
        if (e_pop)
          for (int c = 0; c < FL; c++) q.push_back(frame_bit(bus.fifo_data, c / DIV));
      end else begin
        e_tx = q.pop_front(); e_busy = 1'b1; e_pop = 1'b0;
        e_done = (q.size() == 0);
      end
      n_tests++;
      if ({bus.tx, bus.busy, bus.frame_done, bus.shift_out} !== {e_tx, e_busy, e_done, e_pop}) begin
        n_fail++;
        bad_cnt++;
        if (bad_cnt <= 10)
          $display("FAIL rand cyc %0d: tx/busy/done/pop got %b%b%b%b expected %b%b%b%b", cyc,
                   bus.tx, bus.busy, bus.frame_done, bus.shift_out, e_tx, e_busy, e_done, e_pop);
      end
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
